// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode-side inputs, flush, and the registered EX-side view plus stall status.
interface id_ex_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic              id_reg_dst;
    logic              id_reg_write;
    logic              id_alu_src;
    logic              id_mem_write;
    logic              id_mem_read;
    logic              id_mem_to_reg;
    logic [1:0]        id_alu_op;
    logic [2:0]        id_funct;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              ex_flush;

    logic              stall;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_alu_src;
    logic              ex_mem_write;
    logic              ex_mem_read;
    logic              ex_mem_to_reg;
    logic [1:0]        ex_alu_op;
    logic [2:0]        ex_funct;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_dst;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_reg_dst, id_reg_write, id_alu_src, id_mem_write, id_mem_read,
               id_mem_to_reg, id_alu_op, id_funct, id_rs, id_rt, id_rd, id_rs_data,
               id_rt_data, id_imm, ex_flush,
        input  stall, ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read,
               ex_mem_to_reg, ex_alu_op, ex_funct, ex_rs, ex_rt, ex_dst, ex_rs_data,
               ex_rt_data, ex_imm, stall_count
    );

    modport slave (
        input  id_valid, id_reg_dst, id_reg_write, id_alu_src, id_mem_write, id_mem_read,
               id_mem_to_reg, id_alu_op, id_funct, id_rs, id_rt, id_rd, id_rs_data,
               id_rt_data, id_imm, ex_flush,
        output stall, ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read,
               ex_mem_to_reg, ex_alu_op, ex_funct, ex_rs, ex_rt, ex_dst, ex_rs_data,
               ex_rt_data, ex_imm, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard stall and a saturating stall counter.
// Define LOAD_USE_STALL_EN to enable hazard detection; without it the compiler pads loads with NOPs.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              alu_src;
        logic              mem_write;
        logic              mem_read;
        logic              mem_to_reg;
        logic [1:0]        alu_op;
        logic [2:0]        funct;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dst;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } ex_bundle_t;

    ex_bundle_t ex_q;
    ex_bundle_t id_bundle;
    logic       stall_int;

    // An invalid ID slot carries no control, so it can never write or touch memory in EX.
    always_comb begin
        id_bundle            = '0;
        id_bundle.valid      = bus.id_valid;
        id_bundle.reg_write  = bus.id_valid & bus.id_reg_write;
        id_bundle.alu_src    = bus.id_valid & bus.id_alu_src;
        id_bundle.mem_write  = bus.id_valid & bus.id_mem_write;
        id_bundle.mem_read   = bus.id_valid & bus.id_mem_read;
        id_bundle.mem_to_reg = bus.id_valid & bus.id_mem_to_reg;
        id_bundle.alu_op     = bus.id_valid ? bus.id_alu_op : 2'b00;
        id_bundle.funct      = bus.id_funct;
        id_bundle.rs         = bus.id_rs;
        id_bundle.rt         = bus.id_rt;
        id_bundle.dst        = (bus.id_valid & bus.id_reg_dst) ? bus.id_rd : bus.id_rt;
        id_bundle.rs_data    = bus.id_rs_data;
        id_bundle.rt_data    = bus.id_rt_data;
        id_bundle.imm        = bus.id_imm;
    end

`ifdef LOAD_USE_STALL_EN
    logic             reads_rt;
    logic             hazard;
    logic [CNT_W-1:0] stall_cnt_q;

    // Only R-type and SW read rt; a load's rt is its destination, not a source.
    always_comb begin
        reads_rt = bus.id_reg_dst | bus.id_mem_write;
        hazard   = ex_q.valid & ex_q.mem_read & bus.id_valid & (ex_q.dst != '0)
                 & ((ex_q.dst == bus.id_rs) | (reads_rt & (ex_q.dst == bus.id_rt)));
    end

    assign stall_int = hazard & ~bus.ex_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_int && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_count = stall_cnt_q;
`else
    assign stall_int       = 1'b0;
    assign bus.stall_count = {CNT_W{1'b0}};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (bus.ex_flush || stall_int) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_bundle;
        end
    end

    assign bus.stall         = stall_int;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_funct      = ex_q.funct;
    assign bus.ex_rs         = ex_q.rs;
    assign bus.ex_rt         = ex_q.rt;
    assign bus.ex_dst        = ex_q.dst;
    assign bus.ex_rs_data    = ex_q.rs_data;
    assign bus.ex_rt_data    = ex_q.rt_data;
    assign bus.ex_imm        = ex_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use scenarios then random instructions against an instruction-level model.
module tb_id_ex_stage;
    localparam int DATA_W  = 16;
    localparam int REG_AW  = 3;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    id_ex_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid, reg_dst, reg_write, alu_src, mem_write, mem_read, mem_to_reg;
        logic [1:0]  alu_op;
        logic [2:0]  funct, rs, rt, rd;
        logic [15:0] rs_data, rt_data, imm;
        logic        flush;
    } id_t;

    typedef struct packed {
        logic        valid, reg_write, alu_src, mem_write, mem_read, mem_to_reg;
        logic [1:0]  alu_op;
        logic [2:0]  funct, rs, rt, dst;
        logic [15:0] rs_data, rt_data, imm;
    } ex_t;

    ex_t m_ex;
    int  m_cnt;
    int  total = 0;
    int  bad   = 0;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A load in EX blocks an ID instruction that reads its destination register.
    function automatic bit model_stall(input ex_t ex, input id_t s);
        bit reads_rt;
        if (!STALL_EN || s.flush) return 1'b0;
        if (!(ex.valid && ex.mem_read && s.valid) || ex.dst == 3'd0) return 1'b0;
        reads_rt = s.reg_dst || s.mem_write;
        return (ex.dst == s.rs) || (reads_rt && ex.dst == s.rt);
    endfunction

    function automatic void model_edge(input id_t s);
        bit st;
        st = model_stall(m_ex, s);
        if (s.flush || st) begin
            m_ex = '0;
        end else begin
            m_ex.valid      = s.valid;
            m_ex.reg_write  = s.valid && s.reg_write;
            m_ex.alu_src    = s.valid && s.alu_src;
            m_ex.mem_write  = s.valid && s.mem_write;
            m_ex.mem_read   = s.valid && s.mem_read;
            m_ex.mem_to_reg = s.valid && s.mem_to_reg;
            m_ex.alu_op     = s.valid ? s.alu_op : 2'b00;
            m_ex.funct      = s.funct;
            m_ex.rs         = s.rs;
            m_ex.rt         = s.rt;
            m_ex.dst        = s.reg_dst ? s.rd : s.rt;
            m_ex.rs_data    = s.rs_data;
            m_ex.rt_data    = s.rt_data;
            m_ex.imm        = s.imm;
        end
        if (st && m_cnt < CNT_MAX) m_cnt++;
    endfunction

    task automatic apply_stimulus(input id_t s);
        bus.id_valid      = s.valid;
        bus.id_reg_dst    = s.reg_dst;
        bus.id_reg_write  = s.reg_write;
        bus.id_alu_src    = s.alu_src;
        bus.id_mem_write  = s.mem_write;
        bus.id_mem_read   = s.mem_read;
        bus.id_mem_to_reg = s.mem_to_reg;
        bus.id_alu_op     = s.alu_op;
        bus.id_funct      = s.funct;
        bus.id_rs         = s.rs;
        bus.id_rt         = s.rt;
        bus.id_rd         = s.rd;
        bus.id_rs_data    = s.rs_data;
        bus.id_rt_data    = s.rt_data;
        bus.id_imm        = s.imm;
        bus.ex_flush      = s.flush;
    endtask

    task automatic compare_ex();
        check_output("ex_valid",      32'(bus.ex_valid),      32'(m_ex.valid));
        check_output("ex_reg_write",  32'(bus.ex_reg_write),  32'(m_ex.reg_write));
        check_output("ex_alu_src",    32'(bus.ex_alu_src),    32'(m_ex.alu_src));
        check_output("ex_mem_write",  32'(bus.ex_mem_write),  32'(m_ex.mem_write));
        check_output("ex_mem_read",   32'(bus.ex_mem_read),   32'(m_ex.mem_read));
        check_output("ex_mem_to_reg", 32'(bus.ex_mem_to_reg), 32'(m_ex.mem_to_reg));
        check_output("ex_alu_op",     32'(bus.ex_alu_op),     32'(m_ex.alu_op));
        check_output("ex_rs",         32'(bus.ex_rs),         32'(m_ex.rs));
        check_output("ex_rt",         32'(bus.ex_rt),         32'(m_ex.rt));
        check_output("ex_rs_data",    32'(bus.ex_rs_data),    32'(m_ex.rs_data));
        check_output("ex_rt_data",    32'(bus.ex_rt_data),    32'(m_ex.rt_data));
        check_output("ex_imm",        32'(bus.ex_imm),        32'(m_ex.imm));
        if (m_ex.valid) begin
            check_output("ex_dst",   32'(bus.ex_dst),   32'(m_ex.dst));
            check_output("ex_funct", 32'(bus.ex_funct), 32'(m_ex.funct));
        end
        check_output("stall_count", 32'(bus.stall_count), 32'(m_cnt));
    endtask

    // Entered just after a rising edge; returns whether the model expected a stall this cycle.
    task automatic run_cycle(input id_t s, output bit stalled);
        apply_stimulus(s);
        @(negedge clk);
        stalled = model_stall(m_ex, s);
        check_output("stall", 32'(bus.stall), 32'(stalled));
        @(posedge clk);
        model_edge(s);
        #1;
        compare_ex();
    endtask

    function automatic id_t mk_add(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
        id_t s = '0;
        s.valid = 1'b1; s.reg_dst = 1'b1; s.reg_write = 1'b1; s.alu_op = 2'b10;
        s.rs = rs; s.rt = rt; s.rd = rd;
        s.rs_data = 16'($urandom); s.rt_data = 16'($urandom);
        return s;
    endfunction

    function automatic id_t mk_lw(input logic [2:0] rs, input logic [2:0] rt);
        id_t s = '0;
        s.valid = 1'b1; s.reg_write = 1'b1; s.alu_src = 1'b1; s.mem_read = 1'b1; s.mem_to_reg = 1'b1;
        s.rs = rs; s.rt = rt; s.rd = 3'($urandom);
        s.rs_data = 16'($urandom); s.imm = 16'($urandom);
        return s;
    endfunction

    function automatic id_t mk_sw(input logic [2:0] rs, input logic [2:0] rt);
        id_t s = '0;
        s.valid = 1'b1; s.alu_src = 1'b1; s.mem_write = 1'b1;
        s.rs = rs; s.rt = rt;
        s.rs_data = 16'($urandom); s.rt_data = 16'($urandom); s.imm = 16'($urandom);
        return s;
    endfunction

    function automatic id_t mk_rand();
        id_t s;
        s = id_t'({$urandom, $urandom, $urandom});
        s.rs    = 3'($urandom_range(0, 3));
        s.rt    = 3'($urandom_range(0, 3));
        s.rd    = 3'($urandom_range(0, 3));
        s.valid = ($urandom_range(0, 7) != 0);
        s.flush = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    initial begin
        bit  st;
        id_t s;

        rst_n = 1'b0;
        apply_stimulus('0);
        m_ex  = '0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        compare_ex();
        check_output("rst_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        s = mk_add(3'd1, 3'd2, 3'd3);
        run_cycle(s, st);
        check_output("add_dst", 32'(bus.ex_dst), 32'd3);
        check_output("add_reg_write", 32'(bus.ex_reg_write), 32'd1);

        run_cycle(mk_lw(3'd1, 3'd2), st);
        s = mk_add(3'd2, 3'd4, 3'd5);
        run_cycle(s, st);
        if (st) run_cycle(s, st);
        check_output("held_add_dst", 32'(bus.ex_dst), 32'd5);
        check_output("held_add_valid", 32'(bus.ex_valid), 32'd1);

        run_cycle(mk_lw(3'd1, 3'd2), st);
        run_cycle(mk_lw(3'd5, 3'd2), st);
        s = mk_sw(3'd6, 3'd2);
        run_cycle(s, st);
        if (st) run_cycle(s, st);

        run_cycle(mk_lw(3'd1, 3'd0), st);
        run_cycle(mk_add(3'd0, 3'd0, 3'd1), st);

        run_cycle(mk_lw(3'd1, 3'd2), st);
        s = mk_add(3'd2, 3'd3, 3'd4);
        s.flush = 1'b1;
        run_cycle(s, st);

        repeat (4) begin
            run_cycle(mk_lw(3'd1, 3'd2), st);
            s = mk_add(3'd2, 3'd1, 3'd3);
            run_cycle(s, st);
            if (st) run_cycle(s, st);
        end

        // Reset arriving while a stall is being asserted must clear everything at once.
        run_cycle(mk_lw(3'd1, 3'd2), st);
        s = mk_add(3'd2, 3'd1, 3'd3);
        apply_stimulus(s);
        #2;
        check_output("pre_rst_stall", 32'(bus.stall), 32'(model_stall(m_ex, s)));
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_stall", 32'(bus.stall), 32'd0);
        check_output("mid_rst_valid", 32'(bus.ex_valid), 32'd0);
        check_output("mid_rst_count", 32'(bus.stall_count), 32'd0);
        m_ex  = '0;
        m_cnt = 0;
        apply_stimulus('0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        s = mk_rand();
        repeat (400) begin
            run_cycle(s, st);
            if (st) s.flush = ($urandom_range(0, 7) == 0);
            else    s = mk_rand();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 16-bit pipelined core, with load-use hazard detection. It captures the decode-stage control bundle (reg_dst, reg_write, alu_src, mem_write, mem_read, mem_to_reg, alu_op), the register operands, the immediate and the register numbers, and presents them to EX one cycle later. When a load in EX feeds the instruction in ID, it stalls PC and IF/ID and inserts a bubble. It also keeps a saturating stall counter for performance debug.

## Interface
Parameters:
- DATA_W, 16, datapath and immediate width
- REG_AW, 3, register-number width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst_n  in  1  reset, asynchronous assert, active-low
- id_valid  in  1  ID holds a real instruction
- id_reg_dst, id_reg_write, id_alu_src, id_mem_write, id_mem_read, id_mem_to_reg  in  1 each  decode control bits
- id_alu_op  in  2  decode ALU class
- id_funct  in  3  instruction bits [2:0]
- id_rs, id_rt, id_rd  in  REG_AW  instruction fields [11:9], [8:6], [5:3]
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- ex_flush  in  1  kill the instruction entering EX
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_mem_to_reg  out  1 each  registered control
- ex_alu_op  out  2  registered ALU class
- ex_funct  out  3  registered funct
- ex_rs, ex_rt  out  REG_AW  registered source numbers, for forwarding
- ex_dst  out  REG_AW  registered destination: id_rd if id_reg_dst, else id_rt
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands
- stall_count  out  CNT_W  number of stall cycles, saturating

## Operation
- Source-use rule:
  - ID uses rs when id_valid.
  - ID uses rt only when id_reg_dst or id_mem_write is set (R-type, SW). LW does not read rt.
- Hazard condition: ex_valid & ex_mem_read & id_valid & ex_dst != 0 & (ex_dst == id_rs, or ID uses rt and ex_dst == id_rt).
- stall = hazard & !ex_flush.
- Per-edge load priority, highest first:
  1. ex_flush: load a bubble.
  2. stall: load a bubble.
  3. Otherwise: load the ID fields, with ex_valid = id_valid. When id_valid = 0, every control bit is forced to 0.
- Bubble: ex_valid and all control bits are 0. ex_alu_op = 00. All data and register-number fields are 0.
- ex_dst is computed at load: id_reg_dst ? id_rd : id_rt.
- stall_count:
  - Increments by 1 on each edge where stall = 1.
  - Holds at 2^CNT_W - 1 once saturated; no wrap.
- Register 0 is never a hazard source.

## Timing
- Reset (rst_n = 0, takes effect immediately): every registered output is 0, stall_count = 0. Because ex_valid = 0, stall is 0.
- Latency:
  - ID to EX: 1 cycle.
  - stall: same cycle as the hazard, combinational from registered EX state and ID inputs.
- A load-use hazard costs exactly 1 stall cycle. On the next edge the load moves to MEM and EX holds a bubble, so the hazard clears and ID, which was held upstream, loads normally.
- ex_flush and hazard in the same cycle: stall = 0, bubble loaded, stall_count unchanged.
- Reset asserted mid-stall: the bubble is discarded, outputs clear, and stall deasserts asynchronously.
- Back-to-back loads with no dependence: no stall.

## Configuration
- LOAD_USE_STALL_EN:
  - Defined: hazard detection, stall and stall_count operate as specified above.
  - Undefined: stall is tied to 0, stall_count is tied to 0 and no counter flops exist, and ID always loads unless ex_flush is set. The compiler schedules a NOP after each load.

## Test plan
- Reset, then release: all ex_* = 0, stall = 0, stall_count = 0. Drive ADD (rd=3, reg_dst=1, reg_write=1, alu_op=10, id_valid=1): next cycle ex_dst = 3, ex_reg_write = 1, ex_valid = 1.
- LW r2 in EX, ID = ADD with rs = 2: stall = 1 for exactly one cycle, EX gets a bubble, stall_count = 1. Next cycle the ADD loads and stall = 0.
- LW r2 in EX, ID = LW with rt = 2 and rs = 5: stall = 0, since LW does not read rt. With ID = SW rt = 2: stall = 1.
- LW r0 in EX, ID = ADD with rs = 0: stall = 0.
- Hazard plus ex_flush in the same cycle: stall = 0, bubble loaded, stall_count unchanged.
- CNT_W = 2 with four hazards: stall_count reads 1, 2, 3, 3. Build with LOAD_USE_STALL_EN undefined: same hazard gives stall = 0 and the ADD enters EX immediately.
